// File: rtl/if_stage_buffered.sv
// Buffered instruction-fetch stage: a PC register issues word fetches into a
// single-cycle instruction memory and parks responses in a circular fetch queue.
module if_stage_buffered #(
   parameter int unsigned          PC_WIDTH    = 26,
   parameter int unsigned          QUEUE_DEPTH = 4,
   parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
   parameter logic [31:0]          NOP_WORD    = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic [31:0]         imem_rdata,
   input  logic                is_jump,
   input  logic [PC_WIDTH-1:0] jump_addr,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_addr,
   input  logic                id_ready,
   output logic                if_valid,
   output logic [31:0]         instruction,
   output logic [PC_WIDTH-1:0] next_pc
);

   localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
   localparam logic [CW:0] DEPTH_V = (CW+1)'(QUEUE_DEPTH);
   localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                inflight_q, inflight_d;
   logic [PC_WIDTH-1:0] inflight_npc_q, inflight_npc_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]       count_q, count_d;

   logic [31:0]         instr_mem_q [QUEUE_DEPTH];
   logic [PC_WIDTH-1:0] npc_mem_q   [QUEUE_DEPTH];

   logic                redirect;
   logic [CW:0]         occ_sum;
   logic                room;
   logic                push;
   logic                pop;

   assign redirect = is_jump | branch_taken;
   // In-flight responses reserve a slot so a push can never hit a full queue.
   assign occ_sum  = {1'b0, count_q} + (CW+1)'(inflight_q);
   assign room     = occ_sum < DEPTH_V;
   assign imem_req = rst & room & ~redirect;
   assign push     = inflight_q & ~redirect;
   assign pop      = if_valid & id_ready & ~redirect;

   assign imem_addr   = pc_q;
   assign if_valid    = (count_q != '0);
   assign instruction = if_valid ? instr_mem_q[rd_ptr_q] : NOP_WORD;
   assign next_pc     = if_valid ? npc_mem_q[rd_ptr_q]   : '0;

   always_comb begin
      pc_d           = pc_q;
      inflight_d     = imem_req;
      inflight_npc_d = pc_q + PC_ONE;
      rd_ptr_d       = rd_ptr_q;
      wr_ptr_d       = wr_ptr_q;
      count_d        = count_q;
      if (redirect) begin
         pc_d       = is_jump ? jump_addr : branch_addr;
         inflight_d = 1'b0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (imem_req) pc_d = pc_q + PC_ONE;
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q           <= RESET_PC;
         inflight_q     <= 1'b0;
         inflight_npc_q <= '0;
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         count_q        <= '0;
      end else begin
         pc_q           <= pc_d;
         inflight_q     <= inflight_d;
         inflight_npc_q <= inflight_npc_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         count_q        <= count_d;
      end
   end

   // Entry storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= imem_rdata;
         npc_mem_q[wr_ptr_q]   <= inflight_npc_q;
      end
   end

endmodule
